// File: rtl/butterfly_cmult_pipe_pkg.sv
// -----------------------------------------------------------------------------
// butterfly_cmult_pipe_pkg
// Shared defaults for the FFT twiddle-multiplier datapath and helpers that
// produce the signed saturation bounds for a given output width.
// -----------------------------------------------------------------------------
package butterfly_cmult_pipe_pkg;

   localparam int BF_DATA_W = 16;
   localparam int BF_TW_W   = 16;
   localparam int BF_OUT_W  = 16;
   localparam int BF_ROUND  = 1;
   localparam int BF_CNT_W  = 16;

   // Largest value representable in a w-bit two's-complement word.
   function automatic longint sat_max(input int w);
      return (longint'(1) << (w - 1)) - 1;
   endfunction

   // Smallest value representable in a w-bit two's-complement word.
   function automatic longint sat_min(input int w);
      return -(longint'(1) << (w - 1));
   endfunction

endpackage

// File: rtl/bf_smult.sv
// -----------------------------------------------------------------------------
// bf_smult
// Combinational signed multiplier, full-precision A_W x B_W -> A_W+B_W.
// Ports:
//   a  in  A_W        signed multiplicand
//   b  in  B_W        signed multiplier
//   p  out A_W+B_W    signed product
// -----------------------------------------------------------------------------
module bf_smult #(
   parameter int A_W = 16,
   parameter int B_W = 16
) (
   input  logic signed [A_W-1:0]     a,
   input  logic signed [B_W-1:0]     b,
   output logic signed [A_W+B_W-1:0] p
);

   localparam int P_W = A_W + B_W;

   // Both operands are sign-extended to the product width up front so the
   // multiply is evaluated at full width with no implicit extension.
   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;

   assign a_ext = $signed({{B_W{a[A_W-1]}}, a});
   assign b_ext = $signed({{A_W{b[B_W-1]}}, b});
   assign p     = a_ext * b_ext;

endmodule

// File: rtl/butterfly_cmult_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_cmult_pipe
// Three-stage pipelined complex twiddle multiplier P = A*W with optional
// round-half-up, output saturation, per-sample bypass (P = A) and a saturating
// count of clipped samples handed downstream.
// Ports:
//   xClk, xReset_n        clock, synchronous active-low reset
//   xInValid / xInReady   input handshake (xInReady is combinational)
//   xAr, xAi, xWr, xWi    multiplicand and twiddle, real/imag
//   xBypass               pass A straight through for this sample
//   xOutValid / xOutReady output handshake
//   xPr, xPi, xOvf        product real/imag, sample-clipped flag
//   xSatCount, xSatClear  clipped-sample counter and its synchronous clear
// -----------------------------------------------------------------------------
module butterfly_cmult_pipe
   import butterfly_cmult_pipe_pkg::*;
#(
   parameter int DATA_W = BF_DATA_W,
   parameter int TW_W   = BF_TW_W,
   parameter int OUT_W  = BF_OUT_W,
   parameter int ROUND  = BF_ROUND,
   parameter int CNT_W  = BF_CNT_W
) (
   input  logic              xClk,
   input  logic              xReset_n,
   input  logic              xInValid,
   output logic              xInReady,
   input  logic [DATA_W-1:0] xAr,
   input  logic [DATA_W-1:0] xAi,
   input  logic [TW_W-1:0]   xWr,
   input  logic [TW_W-1:0]   xWi,
   input  logic              xBypass,
   output logic              xOutValid,
   input  logic              xOutReady,
   output logic [OUT_W-1:0]  xPr,
   output logic [OUT_W-1:0]  xPi,
   output logic              xOvf,
   output logic [CNT_W-1:0]  xSatCount,
   input  logic              xSatClear
);

   localparam int PROD_W = DATA_W + TW_W;
   localparam int FULL_W = PROD_W + 1;

   localparam logic signed [FULL_W-1:0] SAT_HI  = FULL_W'(sat_max(OUT_W));
   localparam logic signed [FULL_W-1:0] SAT_LO  = FULL_W'(sat_min(OUT_W));
   localparam logic signed [FULL_W-1:0] RND_ADD =
      FULL_W'((ROUND != 0) ? (longint'(1) << (TW_W - 2)) : longint'(0));

   // Returns {clipped_flag, value limited to the OUT_W signed range}.
   function automatic logic [OUT_W:0] clip(input logic signed [FULL_W-1:0] v);
      if (v > SAT_HI)      return {1'b1, SAT_HI[OUT_W-1:0]};
      else if (v < SAT_LO) return {1'b1, SAT_LO[OUT_W-1:0]};
      else                 return {1'b0, v[OUT_W-1:0]};
   endfunction

   logic enable;

   logic                     s1_valid, s1_bypass;
   logic signed [DATA_W-1:0] s1_ar, s1_ai;
   logic signed [TW_W-1:0]   s1_wr, s1_wi;

   logic signed [PROD_W-1:0] m_rr, m_ii, m_ri, m_ir;

   logic                     s2_valid, s2_bypass;
   logic signed [PROD_W-1:0] s2_rr, s2_ii, s2_ri, s2_ir;
   logic signed [DATA_W-1:0] s2_ar, s2_ai;

   logic signed [FULL_W-1:0] sum_r, sum_i, pre_r, pre_i;
   logic [OUT_W:0]           clip_r, clip_i;

   // The whole pipe moves as one unit: it advances whenever the output slot
   // is empty or being consumed, so a stall freezes every stage in place.
   assign enable   = xOutReady | ~xOutValid;
   assign xInReady = enable;

   // S2 multipliers
   bf_smult #(.A_W(DATA_W), .B_W(TW_W)) u_mult_rr (.a(s1_ar), .b(s1_wr), .p(m_rr));
   bf_smult #(.A_W(DATA_W), .B_W(TW_W)) u_mult_ii (.a(s1_ai), .b(s1_wi), .p(m_ii));
   bf_smult #(.A_W(DATA_W), .B_W(TW_W)) u_mult_ri (.a(s1_ar), .b(s1_wi), .p(m_ri));
   bf_smult #(.A_W(DATA_W), .B_W(TW_W)) u_mult_ir (.a(s1_ai), .b(s1_wr), .p(m_ir));

   // S3 combine, scale and clip. Bypass samples skip rounding and shifting
   // but still pass through the clipper in case OUT_W < DATA_W.
   always_comb begin
      // NOTE: every always_comb output is assigned on all paths (here
      // unconditionally first) so no latch can be inferred.
      sum_r = {s2_rr[PROD_W-1], s2_rr} - {s2_ii[PROD_W-1], s2_ii};
      sum_i = {s2_ri[PROD_W-1], s2_ri} + {s2_ir[PROD_W-1], s2_ir};
      pre_r = (sum_r + RND_ADD) >>> (TW_W - 1);
      pre_i = (sum_i + RND_ADD) >>> (TW_W - 1);
      if (s2_bypass) begin
         pre_r = {{(FULL_W - DATA_W){s2_ar[DATA_W-1]}}, s2_ar};
         pre_i = {{(FULL_W - DATA_W){s2_ai[DATA_W-1]}}, s2_ai};
      end
      clip_r = clip(pre_r);
      clip_i = clip(pre_i);
   end

   // Control and output registers: these carry the defined reset state.
   always_ff @(posedge xClk) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples pre-edge values.
      if (!xReset_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         xOutValid <= 1'b0;
         xPr       <= '0;
         xPi       <= '0;
         xOvf      <= 1'b0;
      end else if (enable) begin
         s1_valid  <= xInValid;
         s2_valid  <= s1_valid;
         xOutValid <= s2_valid;
         xPr       <= clip_r[OUT_W-1:0];
         xPi       <= clip_i[OUT_W-1:0];
         xOvf      <= s2_valid & (clip_r[OUT_W] | clip_i[OUT_W]);
      end
   end

   // NOTE: internal datapath registers have no reset; their contents only
   // matter when the matching valid bit is set, and that bit is reset.
   always_ff @(posedge xClk) begin
      if (enable) begin
         s1_ar     <= $signed(xAr);
         s1_ai     <= $signed(xAi);
         s1_wr     <= $signed(xWr);
         s1_wi     <= $signed(xWi);
         s1_bypass <= xBypass;
         s2_rr     <= m_rr;
         s2_ii     <= m_ii;
         s2_ri     <= m_ri;
         s2_ir     <= m_ir;
         s2_ar     <= s1_ar;
         s2_ai     <= s1_ai;
         s2_bypass <= s1_bypass;
      end
   end

   // Clipped-sample counter: counts on downstream acceptance, sticks at all
   // ones, and a clear wins over a same-cycle increment.
   always_ff @(posedge xClk) begin
      if (!xReset_n) begin
         xSatCount <= '0;
      end else if (xSatClear) begin
         xSatCount <= '0;
      end else if (xOutValid && xOutReady && xOvf && (xSatCount != '1)) begin
         xSatCount <= xSatCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_butterfly_cmult_pipe.sv
// -----------------------------------------------------------------------------
// tb_butterfly_cmult_pipe
// Scoreboard bench: the expected product of every accepted input is pushed
// when the DUT takes it and popped when the DUT hands a sample downstream.
// A second instance with ROUND=0 shares the stimulus for the truncation case.
// -----------------------------------------------------------------------------
module tb_butterfly_cmult_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, in_valid, out_ready, bypass, sat_clear;
   logic [15:0] ar, ai, wr, wi;
   logic        in_ready, out_valid, ovf;
   logic [15:0] pr, pi;
   logic [3:0]  sat_count;

   logic        t_in_ready, t_out_valid, t_ovf;
   logic [15:0] t_pr, t_pi, t_sat_count;

   butterfly_cmult_pipe #(
      .DATA_W(16), .TW_W(16), .OUT_W(16), .ROUND(1), .CNT_W(4)
   ) dut (
      .xClk(clk), .xReset_n(rst_n), .xInValid(in_valid), .xInReady(in_ready),
      .xAr(ar), .xAi(ai), .xWr(wr), .xWi(wi), .xBypass(bypass),
      .xOutValid(out_valid), .xOutReady(out_ready), .xPr(pr), .xPi(pi),
      .xOvf(ovf), .xSatCount(sat_count), .xSatClear(sat_clear)
   );

   butterfly_cmult_pipe #(
      .DATA_W(16), .TW_W(16), .OUT_W(16), .ROUND(0), .CNT_W(16)
   ) dut_trunc (
      .xClk(clk), .xReset_n(rst_n), .xInValid(in_valid), .xInReady(t_in_ready),
      .xAr(ar), .xAi(ai), .xWr(wr), .xWi(wi), .xBypass(bypass),
      .xOutValid(t_out_valid), .xOutReady(out_ready), .xPr(t_pr), .xPi(t_pi),
      .xOvf(t_ovf), .xSatCount(t_sat_count), .xSatClear(sat_clear)
   );

   typedef struct packed {
      logic [15:0] pr;
      logic [15:0] pi;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;

   // Reference model for the ROUND=1, 16-bit instance, in 64-bit integers.
   function automatic exp_t model(input logic [15:0] a_r, a_i, w_r, w_i,
                                  input logic byp);
      longint sar = longint'($signed(a_r));
      longint sai = longint'($signed(a_i));
      longint swr = longint'($signed(w_r));
      longint swi = longint'($signed(w_i));
      longint r, i;
      exp_t   e;
      if (byp) begin
         r = sar;
         i = sai;
      end else begin
         r = (sar * swr - sai * swi + 64'sd16384) >>> 15;
         i = (sar * swi + sai * swr + 64'sd16384) >>> 15;
      end
      e.ovf = 1'b0;
      if (r > 32767)       begin r = 32767;  e.ovf = 1'b1; end
      else if (r < -32768) begin r = -32768; e.ovf = 1'b1; end
      if (i > 32767)       begin i = 32767;  e.ovf = 1'b1; end
      else if (i < -32768) begin i = -32768; e.ovf = 1'b1; end
      e.pr = r[15:0];
      e.pi = i[15:0];
      return e;
   endfunction

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_underflow got pr=%h pi=%h with nothing expected", pr, pi);
            end else begin
               e = sb.pop_front();
               pops++;
               if ({pr, pi, ovf} !== {e.pr, e.pi, e.ovf}) begin
                  errors++;
                  $display("FAIL sb_sample got pr=%h pi=%h ovf=%b expected pr=%h pi=%h ovf=%b",
                           pr, pi, ovf, e.pr, e.pi, e.ovf);
               end
            end
         end
         if (in_valid && in_ready) sb.push_back(model(ar, ai, wr, wi, bypass));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [15:0] a_r, a_i, w_r, w_i, input logic byp);
      ar = a_r; ai = a_i; wr = w_r; wi = w_i; bypass = byp;
   endtask

   task automatic send_one(input logic [15:0] a_r, a_i, w_r, w_i, input logic byp);
      logic acc = 1'b0;
      set_in(a_r, a_i, w_r, w_i, byp);
      in_valid = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL send_timeout got in_ready=0 expected 1 within 10 cycles");
      end
   endtask

   // Returns at the falling edge where out_valid is first seen high.
   task automatic wait_out(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL out_timeout got out_valid=0 expected 1 within 10 cycles");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks += 6;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
      if (pr !== 16'h0)       begin errors++; $display("FAIL reset_pr got %h expected 0000", pr); end
      if (pi !== 16'h0)       begin errors++; $display("FAIL reset_pi got %h expected 0000", pi); end
      if (ovf !== 1'b0)       begin errors++; $display("FAIL reset_ovf got %b expected 0", ovf); end
      if (sat_count !== 4'h0) begin errors++; $display("FAIL reset_sat_count got %h expected 0", sat_count); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_round();
      logic ok;
      send_one(16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b0);
      wait_out(ok);
      if (ok) begin
         checks += 6;
         if (pr !== 16'h4000)      begin errors++; $display("FAIL round_pr got %h expected 4000", pr); end
         if (ovf !== 1'b0)         begin errors++; $display("FAIL round_ovf got %b expected 0", ovf); end
         if (t_out_valid !== 1'b1) begin errors++; $display("FAIL trunc_valid got %b expected 1", t_out_valid); end
         if (t_pr !== 16'h3FFF)    begin errors++; $display("FAIL trunc_pr got %h expected 3fff", t_pr); end
         if (t_pi !== 16'h0000)    begin errors++; $display("FAIL trunc_pi got %h expected 0000", t_pi); end
         if ((t_ovf !== 1'b0) || (t_in_ready !== 1'b1) || (t_sat_count !== 16'h0)) begin
            errors++;
            $display("FAIL trunc_status got ovf=%b ready=%b cnt=%h expected 0 1 0000",
                     t_ovf, t_in_ready, t_sat_count);
         end
      end
      tick();
      drain();
   endtask

   task automatic test_saturate();
      logic ok;
      send_one(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
      wait_out(ok);
      if (ok) begin
         checks += 4;
         if (pr !== 16'h0000)    begin errors++; $display("FAIL sat_pr got %h expected 0000", pr); end
         if (pi !== 16'h7FFF)    begin errors++; $display("FAIL sat_pi got %h expected 7fff", pi); end
         if (ovf !== 1'b1)       begin errors++; $display("FAIL sat_ovf got %b expected 1", ovf); end
         if (sat_count !== 4'h0) begin errors++; $display("FAIL sat_cnt_before got %h expected 0", sat_count); end
      end
      tick();
      checks++;
      if (sat_count !== 4'h1) begin errors++; $display("FAIL sat_cnt_after got %h expected 1", sat_count); end
      drain();
   endtask

   task automatic test_bypass();
      logic ok;
      send_one(16'h1234, 16'hEDCC, 16'h5555, 16'h5555, 1'b1);
      wait_out(ok);
      if (ok) begin
         checks += 3;
         if (pr !== 16'h1234) begin errors++; $display("FAIL bypass_pr got %h expected 1234", pr); end
         if (pi !== 16'hEDCC) begin errors++; $display("FAIL bypass_pi got %h expected edcc", pi); end
         if (ovf !== 1'b0)    begin errors++; $display("FAIL bypass_ovf got %b expected 0", ovf); end
      end
      tick();
      drain();
   endtask

   task automatic test_back_to_back();
      logic [15:0] v_ar[8], v_ai[8], v_wr[8], v_wi[8];
      logic        v_by[8];
      logic [15:0] hold_pr, hold_pi;
      logic        acc, stall;
      int          idx = 0;
      int          pops0 = pops;
      for (int k = 0; k < 8; k++) begin
         v_ar[k] = 16'($urandom); v_ai[k] = 16'($urandom);
         v_wr[k] = 16'($urandom); v_wi[k] = 16'($urandom);
         v_by[k] = 1'($urandom_range(0, 1));
      end
      for (int cyc = 0; cyc < 30; cyc++) begin
         stall     = (cyc >= 4) && (cyc <= 6);
         out_ready = !stall;
         in_valid  = (idx < 8);
         if (idx < 8) set_in(v_ar[idx], v_ai[idx], v_wr[idx], v_wi[idx], v_by[idx]);
         @(negedge clk);
         if (cyc < 12) begin
            checks++;
            if (in_ready !== !stall) begin
               errors++;
               $display("FAIL b2b_in_ready cycle %0d got %b expected %b", cyc, in_ready, !stall);
            end
         end
         if (cyc == 4) begin
            hold_pr = pr;
            hold_pi = pi;
         end else if (cyc == 5 || cyc == 6) begin
            checks++;
            if (out_valid !== 1'b1 || pr !== hold_pr || pi !== hold_pi) begin
               errors++;
               $display("FAIL b2b_hold cycle %0d got v=%b pr=%h pi=%h expected v=1 pr=%h pi=%h",
                        cyc, out_valid, pr, pi, hold_pr, hold_pi);
            end
         end
         acc = in_valid & in_ready;
         tick();
         if (acc) idx++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if ((pops - pops0) != 8 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_count got %0d emerged %0d pending expected 8 emerged 0 pending",
                  pops - pops0, sb.size());
      end
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         set_in(16'(16'h0100 * (k + 1)), 16'h0040, 16'h2000, 16'h1000, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      tick();
      checks += 2;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b expected 0", out_valid); end
      if (sat_count !== 4'h0) begin errors++; $display("FAIL mid_reset_cnt got %h expected 0", sat_count); end
      sb.delete();
      rst_n = 1'b1;
      tick();
      set_in(16'h0100, 16'hFF00, 16'h0200, 16'h0300, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got %b expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== (c == 3)) begin
            errors++;
            $display("FAIL latency cycle %0d got out_valid=%b expected %b", c, out_valid, (c == 3));
         end
         tick();
      end
      drain();
   endtask

   task automatic test_counter();
      in_valid = 1'b1;
      set_in(16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
      for (int k = 0; k < 18; k++) tick();
      in_valid = 1'b0;
      drain();
      checks++;
      if (sat_count !== 4'hF) begin errors++; $display("FAIL cnt_hold got %h expected f", sat_count); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      sat_clear = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || ovf !== 1'b1) begin
         errors++;
         $display("FAIL cnt_clear_setup got v=%b ovf=%b expected 1 1", out_valid, ovf);
      end
      tick();
      sat_clear = 1'b0;
      checks++;
      if (sat_count !== 4'h0) begin errors++; $display("FAIL cnt_clear got %h expected 0", sat_count); end
      drain();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clear = 1'b0;
      set_in(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      test_reset();
      test_round();
      test_saturate();
      test_bypass();
      test_back_to_back();
      test_reset_midstream();
      test_counter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
